// File: rtl/spike_rate_decoder_q8_8_pkg.sv
// Shared Q8.8 types and constants for the SNN spike encode/decode path.
package snn_q8_8_pkg;

  typedef logic signed [15:0] q8_8_t;

  localparam int    Q_FRAC = 8;
  // 1.0 in Q8.8: the rate of a neuron that fires every cycle.
  localparam q8_8_t Q_ONE  = 16'sh0100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } dec_state_e;

endpackage

// File: rtl/spike_rate_decoder_q8_8_if.sv
// Spike-in / window-result-out bundle for the rate decoder.
interface spike_rate_decoder_q8_8_if
  import snn_q8_8_pkg::*;
#(
  parameter int WINDOW_LOG2 = 6,
  parameter int ISI_W       = 16
);
  logic                   en;
  logic                   clear;
  logic                   spike;
  logic                   out_ready;
  logic                   out_valid;
  q8_8_t                  rate_out;
  logic [WINDOW_LOG2:0]   count_out;
  logic [ISI_W-1:0]       min_isi_out;
  logic                   overrun;

  modport master (
    output en, clear, spike, out_ready,
    input  out_valid, rate_out, count_out, min_isi_out, overrun
  );

  modport slave (
    input  en, clear, spike, out_ready,
    output out_valid, rate_out, count_out, min_isi_out, overrun
  );
endinterface

// File: rtl/spike_rate_decoder_q8_8_isi_tracker.sv
// Inter-spike interval tracker: saturating ISI counter and per-window minimum.
module isi_tracker
  import snn_q8_8_pkg::*;
#(
  parameter int ISI_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,     // enabled, non-clear cycle
  input  logic             i_spike,
  input  logic             i_clear,
  input  logic             i_restart,  // window completes this cycle
  output logic [ISI_W-1:0] o_min_next  // minimum including this cycle's spike
);

  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic [ISI_W-1:0] r_isi;
  logic [ISI_W-1:0] r_min;
  logic             r_seen;
  logic [ISI_W-1:0] w_inc;
  logic             w_hit;

  // The incremented count doubles as the candidate interval on a spike.
  assign w_inc      = (r_isi == ISI_MAX) ? ISI_MAX : r_isi + 1'b1;
  assign w_hit      = i_step & i_spike & r_seen;
  assign o_min_next = (w_hit && (w_inc < r_min)) ? w_inc : r_min;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isi  <= '0;
      r_seen <= 1'b0;
      r_min  <= ISI_MAX;
    end else if (i_clear) begin
      r_isi  <= '0;
      r_seen <= 1'b0;
      r_min  <= ISI_MAX;
    end else if (i_step) begin
      if (i_spike) begin
        r_isi  <= '0;
        r_seen <= 1'b1;
      end else begin
        r_isi  <= w_inc;
      end
      r_min <= i_restart ? ISI_MAX : o_min_next;
    end
  end

endmodule

// File: rtl/spike_rate_decoder_q8_8.sv
// Converts a LIF spike stream back to a Q8.8 rate per power-of-two window,
// with min-ISI and a valid/ready result register.
module spike_rate_decoder_q8_8
  import snn_q8_8_pkg::*;
#(
  parameter int WINDOW_LOG2 = 6,
  parameter int ISI_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  spike_rate_decoder_q8_8_if.slave bus
);

  localparam int                   CNT_W    = WINDOW_LOG2 + 1;
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
  localparam logic [CNT_W-1:0]     CNT_FULL = {1'b1, {WINDOW_LOG2{1'b0}}};

  dec_state_e              r_state;
  dec_state_e              w_state_nxt;
  logic                    w_step;

  logic [WINDOW_LOG2-1:0]  r_win;
  logic [CNT_W-1:0]        r_spk;
  logic [CNT_W-1:0]        w_final;
  logic                    w_done;
  logic                    w_free;
  logic [15:0]             w_rate;
  logic [ISI_W-1:0]        w_min_next;

  logic                    r_valid;
  q8_8_t                   r_rate;
  logic [CNT_W-1:0]        r_count;
  logic [ISI_W-1:0]        r_min_isi;
  logic                    r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (bus.en)  w_state_nxt = ST_ACCUM;
        ST_ACCUM: if (!bus.en) w_state_nxt = ST_IDLE;
        default:               w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // The first enabled cycle out of IDLE is already a counted window cycle.
  always_comb begin
    w_step = 1'b0;
    unique case (r_state)
      ST_IDLE:  w_step = bus.en & ~bus.clear;
      ST_ACCUM: w_step = bus.en & ~bus.clear;
      default:  w_step = 1'b0;
    endcase
  end

  assign w_done  = w_step & (r_win == WIN_LAST);
  assign w_final = r_spk + {{WINDOW_LOG2{1'b0}}, bus.spike};
  assign w_free  = ~r_valid | bus.out_ready;
  assign w_rate  = (w_final == CNT_FULL) ? Q_ONE
                 : ({{(16-CNT_W){1'b0}}, w_final} << (Q_FRAC - WINDOW_LOG2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= '0;
      r_spk <= '0;
    end else if (bus.clear) begin
      r_win <= '0;
      r_spk <= '0;
    end else if (w_step) begin
      r_win <= r_win + 1'b1;
      r_spk <= w_done ? '0 : w_final;
    end
  end

  isi_tracker #(.ISI_W(ISI_W)) u_isi (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_step),
    .i_spike    (bus.spike),
    .i_clear    (bus.clear),
    .i_restart  (w_done),
    .o_min_next (w_min_next)
  );

  // A completed window is only published into a free slot; otherwise dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_rate    <= '0;
      r_count   <= '0;
      r_min_isi <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_done && w_free) begin
        r_valid   <= 1'b1;
        r_rate    <= w_rate;
        r_count   <= w_final;
        r_min_isi <= w_min_next;
      end else if (r_valid && bus.out_ready) begin
        r_valid   <= 1'b0;
      end
      if (bus.clear)              r_overrun <= 1'b0;
      else if (w_done && !w_free) r_overrun <= 1'b1;
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.rate_out    = r_rate;
  assign bus.count_out   = r_count;
  assign bus.min_isi_out = r_min_isi;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder_q8_8.sv
// Directed + randomized bench for spike_rate_decoder_q8_8 against a timestamp model.
module tb_spike_rate_decoder_q8_8;

  localparam int WL  = 6;
  localparam int IW  = 16;
  localparam int WIN = 1 << WL;
  localparam int ISI_SAT = (1 << IW) - 1;

  logic clk = 1'b0;
  logic rst;

  spike_rate_decoder_q8_8_if #(.WINDOW_LOG2(WL), .ISI_W(IW)) bus();

  spike_rate_decoder_q8_8 #(.WINDOW_LOG2(WL), .ISI_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Reference: window position, spike timestamps in enabled cycles, published slot.
  bit     m_valid, m_ov, seen;
  int     m_count, m_rate, m_min;
  int     pos, scnt, mn;
  longint gidx, last_t;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ov = 0; m_count = 0; m_rate = 0; m_min = 0;
    pos = 0; scnt = 0; mn = ISI_SAT; seen = 0; gidx = 0; last_t = 0;
  endtask

  task automatic model_edge(bit en, bit clr, bit spk, bit rdy);
    bit consumed;
    consumed = m_valid && rdy;
    if (clr) begin
      pos = 0; scnt = 0; mn = ISI_SAT; seen = 0; m_ov = 0;
      if (consumed) m_valid = 0;
    end else if (en) begin
      if (spk) begin
        if (seen) begin
          longint d;
          d = gidx - last_t;
          if (d > ISI_SAT) d = ISI_SAT;
          if (d < mn) mn = int'(d);
        end
        last_t = gidx;
        seen   = 1;
        scnt++;
      end
      gidx++;
      if (pos == WIN - 1) begin
        pos = 0;
        if (!m_valid || rdy) begin
          m_count = scnt;
          m_rate  = scnt * 256 / WIN;
          m_min   = mn;
          m_valid = 1;
        end else begin
          m_ov = 1;
        end
        scnt = 0;
        mn   = ISI_SAT;
      end else begin
        pos++;
        if (consumed) m_valid = 0;
      end
    end else if (consumed) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    chk("valid",   {31'b0, bus.out_valid},   32'(m_valid));
    chk("count",   {25'b0, bus.count_out},   32'(m_count));
    chk("rate",    {16'b0, bus.rate_out},    32'(m_rate));
    chk("min_isi", {16'b0, bus.min_isi_out}, 32'(m_min));
    chk("overrun", {31'b0, bus.overrun},     32'(m_ov));
  endtask

  task automatic step(bit en, bit clr, bit spk, bit rdy);
    bus.en = en; bus.clear = clr; bus.spike = spk; bus.out_ready = rdy;
    @(posedge clk);
    model_edge(en, clr, spk, rdy);
    #1;
    check_all();
  endtask

  function automatic logic [WIN-1:0] rmask(int n);
    logic [WIN-1:0] m;
    int k;
    m = '0;
    k = 0;
    while (k < n) begin
      int b;
      b = int'($urandom_range(WIN - 1));
      if (!m[b]) begin
        m[b] = 1'b1;
        k++;
      end
    end
    return m;
  endfunction

  logic [WIN-1:0] mask;

  initial begin
    rst = 1'b1;
    bus.en = 0; bus.clear = 0; bus.spike = 0; bus.out_ready = 0;
    model_reset();
    phase = "reset";
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0);

    // Spike every 4th cycle, two windows.
    phase = "every4";
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < WIN; i++) begin
        step(1, 0, (i % 4) == 0, 1);
        if (w == 0 && i == WIN - 2) chk("pre_valid", {31'b0, bus.out_valid}, 32'd0);
        if (i == WIN - 1) begin
          chk("valid_k", {31'b0, bus.out_valid},   32'd1);
          chk("count_k", {25'b0, bus.count_out},   32'd16);
          chk("rate_k",  {16'b0, bus.rate_out},    32'h0040);
          chk("min_k",   {16'b0, bus.min_isi_out}, 32'd4);
        end
      end
    step(0, 1, 0, 1);

    phase = "every1";
    for (int i = 0; i < WIN; i++) step(1, 0, 1, 1);
    chk("count_k", {25'b0, bus.count_out},   32'd64);
    chk("rate_k",  {16'b0, bus.rate_out},    32'h0100);
    chk("min_k",   {16'b0, bus.min_isi_out}, 32'd1);
    step(0, 1, 0, 1);

    phase = "none";
    for (int i = 0; i < WIN; i++) step(1, 0, 0, 1);
    chk("count_k", {25'b0, bus.count_out},   32'd0);
    chk("rate_k",  {16'b0, bus.rate_out},    32'h0000);
    chk("min_k",   {16'b0, bus.min_isi_out}, 32'hFFFF);
    step(0, 1, 0, 1);

    // Two completions with the slot blocked: first result held, overrun set.
    phase = "overrun";
    mask = rmask(10);
    for (int i = 0; i < WIN; i++) step(1, 0, mask[i], 0);
    mask = rmask(20);
    for (int i = 0; i < WIN; i++) step(1, 0, mask[i], 0);
    chk("valid_k",   {31'b0, bus.out_valid}, 32'd1);
    chk("count_k",   {25'b0, bus.count_out}, 32'd10);
    chk("overrun_k", {31'b0, bus.overrun},   32'd1);
    step(0, 1, 0, 0);
    chk("clr_ov_k",    {31'b0, bus.overrun},   32'd0);
    chk("clr_valid_k", {31'b0, bus.out_valid}, 32'd1);
    step(0, 0, 0, 1);

    // en toggling; spikes only while disabled, then spikes in both phases.
    phase = "toggle";
    step(0, 1, 0, 1);
    for (int i = 0; i < 2 * WIN; i++) begin
      step((i % 2) == 0, 0, (i % 2) == 1, 1);
      if (i == 2 * WIN - 2) begin
        chk("valid_k", {31'b0, bus.out_valid}, 32'd1);
        chk("count_k", {25'b0, bus.count_out}, 32'd0);
      end
    end
    for (int i = 0; i < 2 * WIN; i++)
      step((i % 2) == 0, 0, 1'($urandom_range(1)), 0);

    // Async reset mid-window, with a result still held.
    phase = "midreset";
    step(0, 1, 0, 0);
    for (int i = 0; i < 30; i++) step(1, 0, (i < 14) && (i % 2 == 0), 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mask = rmask(12);
    for (int i = 0; i < WIN; i++) step(1, 0, mask[i], 1);

    // Five spikes per window; ISI straddling the window boundary.
    phase = "straddle";
    mask = '0;
    mask[10] = 1; mask[20] = 1; mask[30] = 1; mask[40] = 1; mask[63] = 1;
    for (int i = 0; i < WIN; i++) step(1, 0, mask[i], 1);
    mask = '0;
    mask[2] = 1; mask[15] = 1; mask[30] = 1; mask[45] = 1; mask[60] = 1;
    for (int i = 0; i < WIN; i++) step(1, 0, mask[i], 1);
    chk("min_k",     {16'b0, bus.min_isi_out}, 32'd3);
    chk("count_k",   {25'b0, bus.count_out},   32'd5);
    chk("overrun_k", {31'b0, bus.overrun},     32'd0);
    mask = rmask(5);
    for (int i = 0; i < WIN; i++) step(1, 0, mask[i], 1);

    phase = "soak";
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, ($urandom % 200) == 0,
           ($urandom % 3) == 0, 1'($urandom_range(1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder_q8_8.md
Name: spike_rate_decoder_q8_8

Overview:
Receiving end of the neuron spike interface. Consumes the 1-bit spike flag from a LIF neuron and converts it back to a Q8.8 firing rate, in spikes per cycle. It counts spikes over a fixed power-of-two window of enabled cycles and tracks the minimum inter-spike interval (ISI). Each window result is published through a valid/ready output register to downstream readout or TMR voter logic.

Parameters:
WINDOW_LOG2, 6, window length = 2^WINDOW_LOG2 enabled cycles; legal range 1..8.
ISI_W, 16, width of ISI counters; saturating.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  cycle enable; spikes and window cycles count only when en=1
clear  in  1  synchronous restart of current window; clears overrun
spike  in  1  spike flag from neuron, sampled every enabled cycle
out_ready  in  1  downstream accepts result
out_valid  out  1  result register holds unconsumed window result
rate_out  out  16  signed Q8.8 rate = count / 2^WINDOW_LOG2
count_out  out  WINDOW_LOG2+1  raw spike count of window
min_isi_out  out  ISI_W  minimum ISI in window, in enabled cycles; all-ones if <2 spike events observed
overrun  out  1  sticky: a window completed while out_valid=1 and out_ready=0

Behaviour:
- Reset (async): all outputs 0, including min_isi_out and overrun. Internal counters 0. FSM to IDLE. "Spike seen" flag cleared.
- FSM:
  - IDLE -> ACCUM on first cycle with en=1; that cycle is window cycle 0.
  - ACCUM -> IDLE when en=0. Counters hold; window resumes when en returns, with no restart.
- Window counter win_cnt, WINDOW_LOG2 bits:
  - Increments on each enabled cycle; wraps to 0 after 2^WINDOW_LOG2-1.
  - Spike counter spk_cnt, WINDOW_LOG2+1 bits: += spike on enabled cycles. Max value 2^WINDOW_LOG2, so it never overflows.
- Window completion:
  - Occurs on the enabled cycle where win_cnt = 2^WINDOW_LOG2-1; that cycle's spike is included.
  - At that edge, if the output slot is free (out_valid=0, or out_ready=1 in the same cycle):
    - count_out <= final count.
    - rate_out <= zero-extend(final count) << (8-WINDOW_LOG2), i.e. count·256/2^WINDOW_LOG2. Max 0x0100 = 1.0.
    - min_isi_out <= window minimum.
    - out_valid <= 1.
  - Latency: result visible the cycle after the last window cycle.
  - spk_cnt and window minimum restart at the same edge. The next window starts on the next enabled cycle; there are no dead cycles.
- Handshake:
  - Transfer occurs when out_valid & out_ready. out_valid drops the next cycle unless a new result is loaded in that same cycle.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - If a window completes while out_valid=1 and out_ready=0: the new result is dropped, the held result is retained, and overrun <= 1.
- ISI tracking:
  - isi_cnt increments every enabled cycle and saturates at all-ones. On a spike it resets to 0.
  - If the spike-seen flag is set at a spike, candidate = isi_cnt+1 (saturated). The window minimum takes min(current, candidate).
  - The window minimum is initialised to all-ones at each window start.
  - isi_cnt and the spike-seen flag persist across window boundaries, so the first spike of a window measures from the previous window's last spike.
- clear (synchronous, priority over en):
  - Zeroes win_cnt, spk_cnt and isi_cnt; window minimum <= all-ones; spike-seen flag <= 0; overrun <= 0.
  - The output register and out_valid are untouched.
  - FSM goes to IDLE.
  - A spike during a clear cycle is ignored.
- Simultaneous events:
  - Window completion plus out_ready with out_valid=1: old result consumed, new one loaded, out_valid stays 1, no overrun.
  - clear plus window completion: clear wins and no result is loaded.
- Reset mid-window discards all partial state.
- Spikes with en=0 are ignored.

Decomposition:
- Shared package snn_q8_8_pkg:
  - Q8.8 typedef (signed 16-bit).
  - Q_FRAC=8.
  - Q_ONE=16'h0100.
  - Saturation helper constants.
- One natural sub-module: isi_tracker (isi_cnt, spike-seen flag, running minimum, window restart input).
- Window/spike counters, FSM and output register stay in the top.

Test Plan:
- WINDOW_LOG2=6, en=1, spike every 4th cycle -> each window: count_out=16, rate_out=0x0040, min_isi_out=4, out_valid one cycle after the 64th cycle.
- Spike every cycle -> count_out=64, rate_out=0x0100, min_isi_out=1. No spikes -> count_out=0, rate_out=0x0000, min_isi_out=0xFFFF.
- out_ready=0 across two window completions, with window 1 having 10 spikes and window 2 having 20 -> out_valid=1, count_out=10 retained, overrun=1. Pulse clear -> overrun=0 while out_valid stays 1.
- en toggled 1 cycle on / 1 off, spikes only while en=0 -> window completes after 128 clocks with count_out=0. Spikes during en=1 are counted, and min_isi is measured in enabled cycles.
- Assert rst at window cycle 30 with 7 spikes accumulated -> all outputs 0 immediately. After release, the next result reflects only post-reset spikes.
- out_ready held 1, spike pattern giving 5 spikes per window -> a fresh result every 64 cycles, no overrun. With the last window spike at cycle 63 and next at cycle 2 of the following window -> next min_isi_out ≤ 3.
